reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 23 ++
 rtl/reg_scoreboard_sb_counter.sv | 28 ++
 rtl/reg_scoreboard.sv | 84 ++++++++
 tb/tb_reg_scoreboard.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: op-class encoding,
// default per-class latencies and latency saturation helper.
package reg_scoreboard_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ALU  = 2'd1,
        OP_MEM  = 2'd2,
        OP_MUL  = 2'd3
    } op_cls_e;

    localparam int unsigned DEF_LAT_ALU = 3;
    localparam int unsigned DEF_LAT_MEM = 3;
    localparam int unsigned DEF_LAT_MUL = 4;

    // Clamp a latency to the largest value a w-bit counter can hold.
    function automatic int unsigned sat_lat(input int unsigned lat, input int unsigned w);
        int unsigned max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (lat > max_v) ? max_v : lat;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One scoreboard entry: down-counter with load, hold and clear that stops
// at zero instead of wrapping.
module sb_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             stall,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count
);

    // Clear outranks stall; load outranks the decrement of the same edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (stall) begin
            count <= count;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write countdown with
// combinational busy/remaining-cycle queries for two source operands.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS   = 8,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned LAT_ALU = DEF_LAT_ALU,
    parameter int unsigned LAT_MEM = DEF_LAT_MEM,
    parameter int unsigned LAT_MUL = DEF_LAT_MUL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_decode,
    input  logic                     stall,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    input  logic [1:0]               issue_cls,
    input  logic [CNT_W-1:0]         issue_nex,
    input  logic [$clog2(NREGS)-1:0] rs_a,
    input  logic [$clog2(NREGS)-1:0] rs_b,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [CNT_W-1:0]         cnt_a,
    output logic [CNT_W-1:0]         cnt_b,
    output logic                     any_busy
);

    localparam int unsigned RW = $clog2(NREGS);

    localparam logic [CNT_W-1:0] LD_ALU = CNT_W'(sat_lat(LAT_ALU, CNT_W));
    localparam logic [CNT_W-1:0] LD_MEM = CNT_W'(sat_lat(LAT_MEM, CNT_W));
    localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(sat_lat(LAT_MUL, CNT_W));

    logic [CNT_W-1:0] cnt [NREGS];
    logic [CNT_W-1:0] load_val;
    logic             accept;

    always_comb begin
        load_val = '0;
        if (issue_nex != '0) begin
            load_val = issue_nex;
        end else begin
            unique case (op_cls_e'(issue_cls))
                OP_ALU:  load_val = LD_ALU;
                OP_MEM:  load_val = LD_MEM;
                OP_MUL:  load_val = LD_MUL;
                default: load_val = '0;
            endcase
        end
    end

    assign accept = issue_valid && !stall && !flush_decode && !reset;

    // Register 0 is hardwired idle, so only entries 1..NREGS-1 get storage.
    assign cnt[0] = '0;

    for (genvar g = 1; g < NREGS; g++) begin : g_entry
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clear    (flush_decode),
            .stall    (stall),
            .load     (accept && (issue_rd == RW'(g))),
            .load_val (load_val),
            .count    (cnt[g])
        );
    end

    assign cnt_a  = cnt[rs_a];
    assign cnt_b  = cnt[rs_b];
    assign busy_a = (cnt_a != '0);
    assign busy_b = (cnt_b != '0);

    always_comb begin
        any_busy = 1'b0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            any_busy = any_busy | (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, saturation
// checks on a narrow-parameter instance, and a randomized model comparison.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset, flush_decode, stall, issue_valid;
    logic [2:0] issue_rd, issue_nex, rs_a, rs_b;
    logic [1:0] issue_cls;
    logic       busy_a, busy_b, any_busy;
    logic [2:0] cnt_a, cnt_b;

    logic       s_reset, s_flush, s_stall, s_valid;
    logic [1:0] s_rd, s_cls, s_rs_a, s_rs_b;
    logic [2:0] s_nex;
    logic       s_busy_a, s_busy_b, s_any;
    logic [2:0] s_cnt_a, s_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .flush_decode(flush_decode), .stall(stall),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_cls(issue_cls),
        .issue_nex(issue_nex), .rs_a(rs_a), .rs_b(rs_b),
        .busy_a(busy_a), .busy_b(busy_b), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .any_busy(any_busy)
    );

    reg_scoreboard #(
        .NREGS(4), .CNT_W(3), .LAT_ALU(7), .LAT_MEM(2), .LAT_MUL(12)
    ) dut_sat (
        .clk(clk), .reset(s_reset), .flush_decode(s_flush), .stall(s_stall),
        .issue_valid(s_valid), .issue_rd(s_rd), .issue_cls(s_cls),
        .issue_nex(s_nex), .rs_a(s_rs_a), .rs_b(s_rs_b),
        .busy_a(s_busy_a), .busy_b(s_busy_b), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b),
        .any_busy(s_any)
    );

    typedef struct {
        logic       rst, fl, st, v;
        logic [2:0] rd;
        logic [1:0] cls;
        logic [2:0] nex, ra, rb;
        logic [2:0] ea, eb;
        logic       eany;
    } vec_t;

    typedef struct {
        logic [2:0] a, b;
        logic       any;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    logic [2:0] m [8];

    function automatic vec_t mk(input logic rst, fl, st, v, input logic [2:0] rd,
                                input logic [1:0] cls, input logic [2:0] nex, ra, rb,
                                input logic [2:0] ea, eb, input logic eany);
        vec_t t;
        t.rst = rst; t.fl = fl; t.st = st; t.v = v; t.rd = rd; t.cls = cls;
        t.nex = nex; t.ra = ra; t.rb = rb; t.ea = ea; t.eb = eb; t.eany = eany;
        return t;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", nm, idx, act, req);
        end
    endtask

    task automatic drive(input logic rst, fl, st, v, input logic [2:0] rd,
                         input logic [1:0] cls, input logic [2:0] nex, ra, rb);
        reset = rst; flush_decode = fl; stall = st; issue_valid = v;
        issue_rd = rd; issue_cls = cls; issue_nex = nex; rs_a = ra; rs_b = rb;
    endtask

    task automatic step_and_check(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", idx, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("cnt_a", idx, 32'(cnt_a), 32'(e.a));
            check("cnt_b", idx, 32'(cnt_b), 32'(e.b));
            check("busy_a", idx, 32'(busy_a), 32'(e.a != 3'd0));
            check("busy_b", idx, 32'(busy_b), 32'(e.b != 3'd0));
            check("any_busy", idx, 32'(any_busy), 32'(e.any));
        end
    endtask

    // Reference behaviour: reset/flush zero all, stall holds, load beats decrement.
    task automatic model_edge(input logic rst, fl, st, v, input logic [2:0] rd,
                              input logic [1:0] cls, input logic [2:0] nex);
        logic [2:0] lv;
        lv = (nex != 3'd0) ? nex : (cls == 2'd1) ? 3'd3 : (cls == 2'd2) ? 3'd3 :
             (cls == 2'd3) ? 3'd4 : 3'd0;
        for (int r = 1; r < 8; r++) begin
            if (rst || fl)                      m[r] = 3'd0;
            else if (st)                        m[r] = m[r];
            else if (v && rd == 3'(r))          m[r] = lv;
            else if (m[r] != 3'd0)              m[r] = m[r] - 3'd1;
        end
    endtask

    function automatic logic model_any();
        logic a;
        a = 1'b0;
        for (int r = 1; r < 8; r++) a = a | (m[r] != 3'd0);
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        s_reset = 1; s_flush = 0; s_stall = 0; s_valid = 0;
        s_rd = 0; s_cls = 0; s_nex = 0; s_rs_a = 0; s_rs_b = 0;
        for (int i = 0; i < 8; i++) m[i] = 3'd0;

        //             rst fl st v  rd cls nex ra rb   ea eb any
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 5, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 1, 0, 5, 0,  3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0,  2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0,  1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 3, 0, 2, 0,  4, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0,  3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 0,  3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 0,  3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0,  2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0,  1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4, 1, 6, 4, 0,  6, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 4,  0, 5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4,  0, 4, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 1, 0, 3, 4,  3, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 4,  2, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 4,  1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 2, 0, 3, 4,  3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 4,  2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 3, 4,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 1, 6,  4, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 6, 2, 0, 1, 6,  3, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 7, 1, 0, 7, 6,  3, 2, 1));
        vecs.push_back(mk(0, 1, 0, 1, 5, 3, 0, 5, 1,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 7,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7, 3, 0, 7, 0,  4, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  2, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 7, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 1, 0, 2, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 6, 1, 0, 6, 0,  3, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 6, 0,  0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].st, vecs[i].v, vecs[i].rd,
                  vecs[i].cls, vecs[i].nex, vecs[i].ra, vecs[i].rb);
            e.a = vecs[i].ea; e.b = vecs[i].eb; e.any = vecs[i].eany;
            exp_q.push_back(e);
            step_and_check(i);
        end

        // Narrow instance: out-of-range class latencies must clamp to 7.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("sat_reset_cnt", 100, 32'(s_cnt_a), 32'd0);
        check("sat_reset_any", 100, 32'(s_any), 32'd0);
        s_reset = 0; s_valid = 1; s_rd = 2; s_cls = 3; s_rs_a = 2; s_rs_b = 1;
        @(posedge clk); #1;
        check("sat_mul_clamp", 101, 32'(s_cnt_a), 32'd7);
        s_rd = 1; s_cls = 1;
        @(posedge clk); #1;
        check("sat_alu_fit_b", 102, 32'(s_cnt_b), 32'd7);
        check("sat_dec_a", 102, 32'(s_cnt_a), 32'd6);
        s_rd = 3; s_cls = 3; s_nex = 5; s_rs_a = 3;
        @(posedge clk); #1;
        check("sat_nex_override", 103, 32'(s_cnt_a), 32'd5);
        check("sat_busy_b", 103, 32'(s_busy_b), 32'd1);
        s_valid = 0; s_nex = 0; s_reset = 1;
        @(posedge clk); #1;
        check("sat_any_after_reset", 104, 32'(s_any), 32'd0);

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        model_edge(1, 0, 0, 0, 0, 0, 0);
        e.a = m[0]; e.b = m[0]; e.any = model_any();
        exp_q.push_back(e);
        step_and_check(200);
        for (int i = 0; i < 400; i++) begin
            logic rst, fl, st, v;
            logic [2:0] rd, nex, ra, rb;
            logic [1:0] cls;
            rst = ($urandom_range(0, 99) < 3);
            fl  = ($urandom_range(0, 99) < 5);
            st  = ($urandom_range(0, 99) < 20);
            v   = ($urandom_range(0, 99) < 60);
            rd  = 3'($urandom_range(0, 7));
            cls = 2'($urandom_range(0, 3));
            nex = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            ra  = 3'($urandom_range(0, 7));
            rb  = 3'($urandom_range(0, 7));
            drive(rst, fl, st, v, rd, cls, nex, ra, rb);
            model_edge(rst, fl, st, v, rd, cls, nex);
            e.a = m[ra]; e.b = m[rb]; e.any = model_any();
            exp_q.push_back(e);
            step_and_check(300 + i);
        end

        check("queue_drained", 999, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
